fm_buffer_param: RTL and testbench

//  Parametrised feature-map buffer, successor to the float16 FM RAM. Holds rows of PARA_Y words, one channel plane per output kernel.

---
 rtl/fm_buffer_param_if.sv | 46 ++++
 rtl/fm_buffer_param.sv | 243 ++++++++++++++++++++++++
 tb/tb_fm_buffer_param.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fm_buffer_param_if.sv
// Command/data bundle between the PE array / window fetch and the feature-map buffer.
// master: drives write, zero-fill and read commands; samples ready, write_ready and dout.
// slave : the buffer itself.
interface fm_buffer_param_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int PARA_Y        = 3,
  parameter int PARA_KERNEL   = 2,
  parameter int ADDR_WIDTH    = 8,
  parameter int FM_SIZE_WIDTH = 6
) ();
  logic                                     ena_zero_w;
  logic [ADDR_WIDTH-1:0]                    zero_start_addr;
  logic [ADDR_WIDTH-1:0]                    zero_end_addr;
  logic                                     ena_w;
  logic [ADDR_WIDTH-1:0]                    addr_write;
  logic [PARA_Y*DATA_WIDTH-1:0]             din;
  logic                                     ena_add_write;
  logic                                     ena_para_w;
  logic [ADDR_WIDTH-1:0]                    addr_para_write;
  logic [FM_SIZE_WIDTH-1:0]                 fm_out_size;
  logic [PARA_KERNEL*PARA_Y*DATA_WIDTH-1:0] para_din;
  logic                                     ena_r;
  logic [1:0]                               read_type;
  logic [ADDR_WIDTH-1:0]                    addr_read;
  logic [ADDR_WIDTH-1:0]                    sub_addr_read;
  logic                                     ready;
  logic                                     write_ready;
  logic [PARA_Y*DATA_WIDTH-1:0]             dout;
  logic                                     dout_valid;

  modport master (
    output ena_zero_w, zero_start_addr, zero_end_addr,
    output ena_w, addr_write, din, ena_add_write,
    output ena_para_w, addr_para_write, fm_out_size, para_din,
    output ena_r, read_type, addr_read, sub_addr_read,
    input  ready, write_ready, dout, dout_valid
  );

  modport slave (
    input  ena_zero_w, zero_start_addr, zero_end_addr,
    input  ena_w, addr_write, din, ena_add_write,
    input  ena_para_w, addr_para_write, fm_out_size, para_din,
    input  ena_r, read_type, addr_read, sub_addr_read,
    output ready, write_ready, dout, dout_valid
  );
endinterface

// File: rtl/fm_buffer_param.sv
// Feature-map row buffer: zero fill, single/parallel write with saturating accumulate, 3 read modes.
// Latency: read data 2 edges after request; zero fill N rows busy N cycles; para write K (+1 when accumulating).
// Backpressure: commands accepted only while ready=1; anything presented with ready=0 is dropped, not queued.
// Ports: clk, rst_n (async, active low); fm = slave side of fm_buffer_param_if
//   (zero-fill, single-write, parallel-write and read commands in; ready, write_ready, dout, dout_valid out).
module fm_buffer_param #(
  parameter int DATA_WIDTH    = 16,
  parameter int PARA_Y        = 3,
  parameter int PARA_KERNEL   = 2,
  parameter int ADDR_WIDTH    = 8,
  parameter int FM_SIZE_WIDTH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  fm_buffer_param_if.slave  fm
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int ROW_W = PARA_Y * DATA_WIDTH;
  localparam int KD_W  = PARA_KERNEL * ROW_W;
  localparam int KC_W  = $clog2(PARA_KERNEL + 1);

  typedef enum logic [2:0] {S_IDLE, S_ZERO, S_PARA, S_SINGLE, S_DRAIN} state_t;

  logic [ROW_W-1:0] mem [DEPTH];

  state_t                r_state;
  logic                  r_ready;
  logic                  r_write_ready;
  logic [ADDR_WIDTH-1:0] r_addr;       // row being worked on by the FSM
  logic [ADDR_WIDTH-1:0] r_end;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [KD_W-1:0]       r_para_dat;   // kernel rows; shifted down one row per cycle
  logic                  r_add;
  logic [KC_W-1:0]       r_kleft;
  logic                  r_wb_vld;     // accumulate pipeline write-back stage
  logic [ADDR_WIDTH-1:0] r_wb_addr;
  logic [ROW_W-1:0]      r_wb_dat;
  logic                  r_rd_pend;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_rd_bcast;
  logic [ADDR_WIDTH-1:0] r_rd_sub;
  logic [ROW_W-1:0]      r_dout;
  logic                  r_dout_valid;

  logic                  w_acc_zero, w_acc_para, w_acc_w, w_acc_r;
  logic [ADDR_WIDTH-1:0] w_fm_ext, w_stride;
  logic [ROW_W-1:0]      w_kdat, w_rmw_old, w_rmw_sum;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [ROW_W-1:0]      w_wdat;
  logic [ROW_W-1:0]      w_rd_row, w_bcast;
  logic [DATA_WIDTH-1:0] w_lane;

  // Per-lane signed add clamped to the representable range.
  function automatic logic [ROW_W-1:0] row_add(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b);
    logic [ROW_W-1:0]    r;
    logic [DATA_WIDTH:0] s;
    r = '0;
    for (int i = 0; i < PARA_Y; i++) begin
      s = {a[i*DATA_WIDTH+DATA_WIDTH-1], a[i*DATA_WIDTH +: DATA_WIDTH]}
        + {b[i*DATA_WIDTH+DATA_WIDTH-1], b[i*DATA_WIDTH +: DATA_WIDTH]};
      if (s[DATA_WIDTH] != s[DATA_WIDTH-1])
        r[i*DATA_WIDTH +: DATA_WIDTH] = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else
        r[i*DATA_WIDTH +: DATA_WIDTH] = s[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  // Command arbitration: zero fill > parallel write > single write > read.
  assign w_acc_zero = r_ready & fm.ena_zero_w;
  assign w_acc_para = r_ready & ~fm.ena_zero_w & fm.ena_para_w;
  assign w_acc_w    = r_ready & ~fm.ena_zero_w & ~fm.ena_para_w & fm.ena_w;
  assign w_acc_r    = r_ready & ~fm.ena_zero_w & ~fm.ena_para_w & ~fm.ena_w & fm.ena_r;

  // Plane stride = size^2 mod DEPTH; only the low ADDR_WIDTH bits of size matter.
  assign w_fm_ext = ADDR_WIDTH'(fm.fm_out_size);
  assign w_stride = w_fm_ext * w_fm_ext;

  // RMW read; the write-back stage lands this same edge, so forward it on a row hit.
  assign w_kdat    = r_para_dat[ROW_W-1:0];
  assign w_rmw_old = (r_wb_vld && (r_wb_addr == r_addr)) ? r_wb_dat : mem[r_addr];
  assign w_rmw_sum = row_add(w_rmw_old, w_kdat);

  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_addr;
    w_wdat  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_acc_w && !fm.ena_add_write) begin
          w_we    = 1'b1;
          w_waddr = fm.addr_write;
          w_wdat  = fm.din;
        end
      end
      S_ZERO: w_we = 1'b1;
      S_PARA: begin
        if (r_add) begin
          w_we    = r_wb_vld;
          w_waddr = r_wb_addr;
          w_wdat  = r_wb_dat;
        end else begin
          w_we   = 1'b1;
          w_wdat = w_kdat;
        end
      end
      S_SINGLE: begin
        w_we   = 1'b1;
        w_wdat = w_rmw_sum;
      end
      S_DRAIN: begin
        w_we    = r_wb_vld;
        w_waddr = r_wb_addr;
        w_wdat  = r_wb_dat;
      end
      default: w_we = 1'b0;
    endcase
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_we) mem[w_waddr] <= w_wdat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ready       <= 1'b1;
      r_write_ready <= 1'b0;
      r_addr        <= '0;
      r_end         <= '0;
      r_stride      <= '0;
      r_para_dat    <= '0;
      r_add         <= 1'b0;
      r_kleft       <= '0;
      r_wb_vld      <= 1'b0;
      r_wb_addr     <= '0;
      r_wb_dat      <= '0;
    end else begin
      r_write_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc_zero) begin
            r_state <= S_ZERO;
            r_ready <= 1'b0;
            r_addr  <= fm.zero_start_addr;
            r_end   <= fm.zero_end_addr;
          end else if (w_acc_para) begin
            r_state    <= S_PARA;
            r_ready    <= 1'b0;
            r_addr     <= fm.addr_para_write;
            r_stride   <= w_stride;
            r_para_dat <= fm.para_din;
            r_add      <= fm.ena_add_write;
            r_kleft    <= KC_W'(PARA_KERNEL);
            r_wb_vld   <= 1'b0;
          end else if (w_acc_w) begin
            if (fm.ena_add_write) begin
              r_state    <= S_SINGLE;
              r_ready    <= 1'b0;
              r_addr     <= fm.addr_write;
              r_para_dat <= KD_W'(fm.din);
            end else begin
              r_write_ready <= 1'b1;
            end
          end
        end
        S_ZERO: begin
          r_addr <= r_addr + 1'b1;
          if (r_addr == r_end) begin
            r_state       <= S_IDLE;
            r_ready       <= 1'b1;
            r_write_ready <= 1'b1;
          end
        end
        S_PARA: begin
          r_addr     <= r_addr + r_stride;
          r_para_dat <= r_para_dat >> ROW_W;
          r_kleft    <= r_kleft - 1'b1;
          r_wb_vld   <= r_add;
          r_wb_addr  <= r_addr;
          r_wb_dat   <= w_rmw_sum;
          if (r_kleft == KC_W'(1)) begin
            if (r_add) begin
              r_state <= S_DRAIN;
            end else begin
              r_state       <= S_IDLE;
              r_ready       <= 1'b1;
              r_write_ready <= 1'b1;
            end
          end
        end
        S_SINGLE, S_DRAIN: begin
          r_wb_vld      <= 1'b0;
          r_state       <= S_IDLE;
          r_ready       <= 1'b1;
          r_write_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Read path: latch request at accept, read the RAM one edge later.
  always_comb begin
    w_rd_row = mem[r_rd_addr];
    w_lane   = '0;
    for (int i = 0; i < PARA_Y; i++) begin
      if (r_rd_sub == ADDR_WIDTH'(i)) w_lane = w_rd_row[i*DATA_WIDTH +: DATA_WIDTH];
    end
    w_bcast = {PARA_Y{w_lane}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend    <= 1'b0;
      r_rd_addr    <= '0;
      r_rd_bcast   <= 1'b0;
      r_rd_sub     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_rd_pend <= w_acc_r;
      if (w_acc_r) begin
        r_rd_addr  <= (fm.read_type == 2'd1) ? fm.addr_read + fm.sub_addr_read : fm.addr_read;
        r_rd_bcast <= (fm.read_type == 2'd2);
        r_rd_sub   <= fm.sub_addr_read;
      end
      r_dout_valid <= r_rd_pend;
      if (r_rd_pend) r_dout <= r_rd_bcast ? w_bcast : w_rd_row;
    end
  end

  assign fm.ready       = r_ready;
  assign fm.write_ready = r_write_ready;
  assign fm.dout        = r_dout;
  assign fm.dout_valid  = r_dout_valid;
endmodule

// File: tb/tb_fm_buffer_param.sv
module tb_fm_buffer_param;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  fm_buffer_param_if #(.DATA_WIDTH(16), .PARA_Y(3), .PARA_KERNEL(2), .ADDR_WIDTH(8), .FM_SIZE_WIDTH(6)) bus ();

  fm_buffer_param #(.DATA_WIDTH(16), .PARA_Y(3), .PARA_KERNEL(2), .ADDR_WIDTH(8), .FM_SIZE_WIDTH(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fm    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [47:0] mkrow(input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2);
    return {l2, l1, l0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ena_zero_w = 0; bus.zero_start_addr = 0; bus.zero_end_addr = 0;
    bus.ena_w = 0; bus.addr_write = 0; bus.din = 0; bus.ena_add_write = 0;
    bus.ena_para_w = 0; bus.addr_para_write = 0; bus.fm_out_size = 0; bus.para_din = 0;
    bus.ena_r = 0; bus.read_type = 0; bus.addr_read = 0; bus.sub_addr_read = 0;
  endtask

  // Called right after the accept edge: counts busy cycles until ready returns.
  task automatic wait_done(input string tag, input int exp_busy);
    int busy;
    busy = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus.ready) break;
      busy++;
      cyc();
    end
    chk({tag, "_busy"}, 64'(busy), 64'(exp_busy));
    chk({tag, "_wrdy"}, 64'(bus.write_ready), 64'd1);
  endtask

  task automatic wr1(input string tag, input logic [7:0] a, input logic [47:0] d, input logic add, input int exp_busy);
    bus.ena_w = 1; bus.addr_write = a; bus.din = d; bus.ena_add_write = add;
    cyc();
    bus.ena_w = 0; bus.ena_add_write = 0;
    wait_done(tag, exp_busy);
  endtask

  task automatic zfill(input string tag, input logic [7:0] s, input logic [7:0] e, input int exp_busy);
    bus.ena_zero_w = 1; bus.zero_start_addr = s; bus.zero_end_addr = e;
    cyc();
    bus.ena_zero_w = 0;
    wait_done(tag, exp_busy);
  endtask

  task automatic para(input string tag, input logic [7:0] a, input logic [5:0] fs,
                      input logic [47:0] k0, input logic [47:0] k1, input logic add, input int exp_busy);
    bus.ena_para_w = 1; bus.addr_para_write = a; bus.fm_out_size = fs;
    bus.para_din = {k1, k0}; bus.ena_add_write = add;
    cyc();
    bus.ena_para_w = 0; bus.ena_add_write = 0;
    wait_done(tag, exp_busy);
  endtask

  task automatic rdchk(input string tag, input logic [1:0] t, input logic [7:0] a, input logic [7:0] sub, input logic [47:0] exp);
    bus.ena_r = 1; bus.read_type = t; bus.addr_read = a; bus.sub_addr_read = sub;
    cyc();
    bus.ena_r = 0;
    cyc();
    chk({tag, "_vld"}, 64'(bus.dout_valid), 64'd1);
    chk(tag, 64'(bus.dout), 64'(exp));
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    idle_inputs();
    rst_n = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_wrdy", 64'(bus.write_ready), 64'd0);
    chk("rst_dout", 64'(bus.dout), 64'd0);
    chk("rst_vld", 64'(bus.dout_valid), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    cyc();

    // Zero fill 0..15 with a competing single write: only the fill runs.
    wr1("pre100", 8'd100, mkrow(16'h0A, 16'h0B, 16'h0C), 1'b0, 0);
    bus.ena_w = 1; bus.addr_write = 8'd100; bus.din = mkrow(16'h1, 16'h2, 16'h3);
    zfill("zf16", 8'd0, 8'd15, 16);
    bus.ena_w = 0;
    cyc();
    chk("zf16_pulse", 64'(bus.write_ready), 64'd0);
    for (int r = 0; r < 16; r++) rdchk("zf16_row", 2'd0, 8'(r), 8'd0, 48'd0);
    rdchk("prio_row100", 2'd0, 8'd100, 8'd0, mkrow(16'h0A, 16'h0B, 16'h0C));

    // Wrap-around fill 254..1, row 2 untouched.
    wr1("pre254", 8'd254, mkrow(16'h11, 16'h11, 16'h11), 1'b0, 0);
    wr1("pre255", 8'd255, mkrow(16'h12, 16'h12, 16'h12), 1'b0, 0);
    wr1("pre0", 8'd0, mkrow(16'h13, 16'h13, 16'h13), 1'b0, 0);
    wr1("pre1", 8'd1, mkrow(16'h14, 16'h14, 16'h14), 1'b0, 0);
    wr1("pre2", 8'd2, mkrow(16'h15, 16'h16, 16'h17), 1'b0, 0);
    zfill("zfwrap", 8'd254, 8'd1, 4);
    rdchk("wrap254", 2'd0, 8'd254, 8'd0, 48'd0);
    rdchk("wrap255", 2'd0, 8'd255, 8'd0, 48'd0);
    rdchk("wrap0", 2'd0, 8'd0, 8'd0, 48'd0);
    rdchk("wrap1", 2'd0, 8'd1, 8'd0, 48'd0);
    rdchk("wrap2", 2'd0, 8'd2, 8'd0, mkrow(16'h15, 16'h16, 16'h17));

    // Parallel overwrite, stride 64.
    wr1("pre11", 8'd11, mkrow(16'd21, 16'd22, 16'd23), 1'b0, 0);
    para("pow", 8'd9, 6'd8, mkrow(16'd4, 16'd5, 16'd6), mkrow(16'd1, 16'd2, 16'd3), 1'b0, 2);
    rdchk("pow_row9", 2'd0, 8'd9, 8'd0, mkrow(16'd4, 16'd5, 16'd6));
    rdchk("pow_row73", 2'd0, 8'd73, 8'd0, mkrow(16'd1, 16'd2, 16'd3));

    // Read modes.
    rdchk("rd_t1", 2'd1, 8'd9, 8'd2, mkrow(16'd21, 16'd22, 16'd23));
    rdchk("rd_t2", 2'd2, 8'd9, 8'd1, mkrow(16'd5, 16'd5, 16'd5));
    rdchk("rd_t2_oob", 2'd2, 8'd9, 8'd3, 48'd0);
    rdchk("rd_t3", 2'd3, 8'd9, 8'd2, mkrow(16'd4, 16'd5, 16'd6));
    cyc();
    cyc();
    chk("hold_dout", 64'(bus.dout), 64'(mkrow(16'd4, 16'd5, 16'd6)));
    chk("hold_vld", 64'(bus.dout_valid), 64'd0);

    // Parallel accumulate.
    para("padd", 8'd9, 6'd8, mkrow(16'd4, 16'd5, 16'd6), mkrow(16'd1, 16'd2, 16'd3), 1'b1, 3);
    rdchk("padd_row9", 2'd0, 8'd9, 8'd0, mkrow(16'd8, 16'd10, 16'd12));
    rdchk("padd_row73", 2'd0, 8'd73, 8'd0, mkrow(16'd2, 16'd4, 16'd6));

    // Saturation through single accumulate.
    wr1("pre20", 8'd20, mkrow(16'h7FF0, 16'h8010, 16'h0005), 1'b0, 0);
    wr1("sadd", 8'd20, mkrow(16'h0020, 16'hFFE0, 16'hFFFE), 1'b1, 1);
    rdchk("sat_row20", 2'd0, 8'd20, 8'd0, mkrow(16'h7FFF, 16'h8000, 16'h0003));

    // Forwarding with zero stride: both kernels hit row 5.
    wr1("pre5", 8'd5, mkrow(16'd10, 16'd10, 16'd10), 1'b0, 0);
    para("fwd", 8'd5, 6'd0, mkrow(16'd1, 16'd1, 16'd1), mkrow(16'd2, 16'd2, 16'd2), 1'b1, 3);
    rdchk("fwd_row5", 2'd0, 8'd5, 8'd0, mkrow(16'd13, 16'd13, 16'd13));

    // Reset while a fill is running and read data is valid.
    wr1("pre250", 8'd250, mkrow(16'h0C0, 16'h0C1, 16'h0C2), 1'b0, 0);
    bus.ena_r = 1; bus.read_type = 2'd0; bus.addr_read = 8'd250;
    cyc();
    bus.ena_r = 0;
    bus.ena_zero_w = 1; bus.zero_start_addr = 8'd0; bus.zero_end_addr = 8'd200;
    cyc();
    bus.ena_zero_w = 0;
    chk("mid_vld", 64'(bus.dout_valid), 64'd1);
    chk("mid_dat", 64'(bus.dout), 64'(mkrow(16'h0C0, 16'h0C1, 16'h0C2)));
    chk("mid_busy", 64'(bus.ready), 64'd0);
    #1 rst_n = 0;
    #1;
    chk("arst_ready", 64'(bus.ready), 64'd1);
    chk("arst_vld", 64'(bus.dout_valid), 64'd0);
    chk("arst_wrdy", 64'(bus.write_ready), 64'd0);
    @(posedge clk);
    #1 rst_n = 1;
    cyc();
    cyc();
    chk("post_ready", 64'(bus.ready), 64'd1);
    rdchk("post_row250", 2'd0, 8'd250, 8'd0, mkrow(16'h0C0, 16'h0C1, 16'h0C2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
